mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/mem_lsu.sv | 159 +++++++++++++++
 tb/tb_mem_lsu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 access codes
// and the access-fault rule used when a request is presented in IDLE.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned widths exist only for loads, so a store with BU/HU is illegal.
   function automatic logic access_fault(input logic [2:0] f3,
                                         input logic [1:0] off,
                                         input logic       is_store);
      logic f;
      case (f3)
         F3_B, F3_BU: f = 1'b0;
         F3_H, F3_HU: f = off[0];
         F3_W:        f = (off != 2'b00);
         default:     f = 1'b1;
      endcase
      if (is_store && (f3 == F3_BU || f3 == F3_HU)) f = 1'b1;
      return f;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables and store-data replication on the way out,
// lane selection and sign/zero extension of load data on the way back.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = 8'(bus_rdata >> {offset, 3'b000});
      lane_h = 16'(bus_rdata >> {offset[1], 4'b0000});

      case (funct3[1:0])
         2'b00:   byte_en = 4'b0001 << offset;
         2'b01:   byte_en = 4'b0011 << offset;
         default: byte_en = 4'b1111;
      endcase

      case (funct3[1:0])
         2'b00:   wdata_rep = {4{store_data[7:0]}};
         2'b01:   wdata_rep = {2{store_data[15:0]}};
         default: wdata_rep = store_data;
      endcase

      case (funct3)
         F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
         F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
         F3_W:    load_data = bus_rdata;
         F3_BU:   load_data = {24'd0, lane_b};
         F3_HU:   load_data = {16'd0, lane_h};
         default: load_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one outstanding bus access per M instruction,
// stalling the pipeline from request until the response is captured.
module mem_lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic        HoldM,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        MisalignM,
   output logic        BusErrM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   input  logic        bus_err
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   lsu_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic        req_q, we_q, err_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  be_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   logic        mem_op, fault, access_ok;
   logic        end_err, end_ack, end_tmo;
   logic [2:0]  al_f3;
   logic [1:0]  al_off;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_load;

   assign mem_op    = MemReadM | MemWriteM;
   assign fault     = access_fault(funct3M, ALUResultM[1:0], MemWriteM);
   assign access_ok = mem_op & ~fault;

   // Error wins over ack; timeout only fires when neither response arrived.
   assign end_err = bus_err;
   assign end_ack = bus_ack & ~bus_err;
   assign end_tmo = ~bus_ack & ~bus_err & (cnt_q == CNT_LAST);

   // Issue-side lanes come from the live inputs; return-side from the capture.
   assign al_f3  = (state_q == IDLE) ? funct3M : f3_q;
   assign al_off = (state_q == IDLE) ? ALUResultM[1:0] : off_q;

   lsu_align u_align (
      .funct3     (al_f3),
      .offset     (al_off),
      .store_data (WriteDataM),
      .bus_rdata  (bus_rdata),
      .byte_en    (al_be),
      .wdata_rep  (al_wdata),
      .load_data  (al_load)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (access_ok) state_d = BUSY;
         BUSY:    if (end_err || end_ack || end_tmo) state_d = DONE;
         DONE:    if (!HoldM) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      StallM    = 1'b0;
      MisalignM = 1'b0;
      ReadDataM = 32'd0;
      BusErrM   = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               StallM    = access_ok;
               MisalignM = mem_op & fault;
            end
            BUSY: StallM = 1'b1;
            DONE: begin
               ReadDataM = rdata_q;
               BusErrM   = err_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (access_ok) begin
               req_q   <= 1'b1;
               we_q    <= MemWriteM;
               addr_q  <= {ALUResultM[31:2], 2'b00};
               be_q    <= al_be;
               wdata_q <= al_wdata;
               f3_q    <= funct3M;
               off_q   <= ALUResultM[1:0];
               cnt_q   <= '0;
               rdata_q <= 32'd0;
               err_q   <= 1'b0;
            end
            BUSY: begin
               if (end_err || end_tmo) begin
                  req_q   <= 1'b0;
                  rdata_q <= 32'd0;
                  err_q   <= 1'b1;
                  cnt_q   <= '0;
               end else if (end_ack) begin
                  req_q   <= 1'b0;
                  rdata_q <= we_q ? 32'd0 : al_load;
                  err_q   <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_req   = req_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: each access is predicted from the access
// rules (sizes, lanes, latency, timeout) and compared cycle by cycle.
module tb_mem_lsu;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemReadM, MemWriteM, HoldM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallM, MisalignM, BusErrM;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   logic        bus_ack, bus_err;

   int checks = 0;
   int errors = 0;

   mem_lsu #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .funct3M    (funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .HoldM      (HoldM),
      .ReadDataM  (ReadDataM),
      .StallM     (StallM),
      .MisalignM  (MisalignM),
      .BusErrM    (BusErrM),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_ack    (bus_ack),
      .bus_err    (bus_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic m_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
      if (wr && f3 > 2) return 1'b1;
      if (f3 == 1 || f3 == 5) return a[0];
      if (f3 == 2) return (a[1:0] != 0);
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] rd);
      int sz;
      logic [31:0] mask, v;
      sz = 1 << f3[1:0];
      if (sz == 4) return rd;
      mask = (32'd1 << (8 * sz)) - 1;
      v = (rd >> (8 * a[1:0])) & mask;
      if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
      return v;
   endfunction

   task automatic do_access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input int dly, input logic e,
                            input logic [31:0] rd, input int hold);
      int          sz, n_busy, stalls;
      logic [31:0] e_be, e_wd, e_rd;
      logic        e_err;
      MemReadM = ~wr; MemWriteM = wr; funct3M = f3; ALUResultM = a; WriteDataM = d;
      HoldM = 1'b0;
      #1;
      if (m_fault(wr, f3, a)) begin
         check("misalign", MisalignM, 1);
         check("fault_stall", StallM, 0);
         check("fault_req", bus_req, 0);
         @(posedge clk); #1;
         check("fault_noreq", bus_req, 0);
         MemReadM = 1'b0; MemWriteM = 1'b0;
         $display("access fault we=%0b f3=%0d addr=%h", wr, f3, a);
         return;
      end
      sz   = 1 << f3[1:0];
      e_be = ((32'd1 << sz) - 1) << a[1:0];
      e_wd = (sz == 1) ? d[7:0] * 32'h0101_0101 : (sz == 2) ? d[15:0] * 32'h0001_0001 : d;
      if (dly >= TMO) begin
         n_busy = TMO; e_err = 1'b1; e_rd = 0;
      end else begin
         n_busy = dly + 1;
         e_err  = e;
         e_rd   = (e || wr) ? 32'd0 : m_load(f3, a, rd);
      end
      check("idle_stall", StallM, 1);
      check("idle_misalign", MisalignM, 0);
      check("idle_req", bus_req, 0);
      stalls = int'(StallM);
      @(posedge clk); #1;
      for (int k = 0; k < n_busy; k++) begin
         check("busy_req", bus_req, 1);
         check("busy_addr", bus_addr, a & 32'hFFFF_FFFC);
         check("busy_be", {28'd0, bus_be}, e_be);
         check("busy_we", bus_we, wr);
         check("busy_wdata", bus_wdata, e_wd);
         stalls += int'(StallM);
         if (k == dly) begin
            bus_ack = 1'b1; bus_err = e; bus_rdata = rd;
         end else begin
            bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
         end
         @(posedge clk); #1;
         bus_ack = 1'b0; bus_err = 1'b0;
      end
      check("stall_cycles", stalls, n_busy + 1);
      for (int h = 0; h <= hold; h++) begin
         HoldM = (h < hold);
         if (h == hold) begin MemReadM = 1'b0; MemWriteM = 1'b0; end
         #1;
         check("done_stall", StallM, 0);
         check("done_req", bus_req, 0);
         check("done_rdata", ReadDataM, e_rd);
         check("done_buserr", BusErrM, e_err);
         @(posedge clk); #1;
      end
      HoldM = 1'b0;
      check("after_stall", StallM, 0);
      check("after_rdata", ReadDataM, 0);
      check("after_buserr", BusErrM, 0);
      $display("access we=%0b f3=%0d addr=%h busy=%0d hold=%0d rdata=%h err=%0b",
               wr, f3, a, n_busy, hold, e_rd, e_err);
   endtask

   initial begin
      rst = 1'b1; HoldM = 1'b0; MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010;
      ALUResultM = 0; WriteDataM = 0; bus_rdata = 0; bus_ack = 1'b0; bus_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", StallM, 0);
      check("rst_misalign", MisalignM, 0);
      check("rst_buserr", BusErrM, 0);
      check("rst_rdata", ReadDataM, 0);
      check("rst_req", bus_req, 0);
      check("rst_addr", bus_addr, 0);
      check("rst_be", {28'd0, bus_be}, 0);
      check("rst_wdata", bus_wdata, 0);
      check("rst_we", bus_we, 0);
      MemReadM = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // LB sign extension with immediate ack
      do_access(1'b0, 3'b000, 32'h1003, 32'h0, 0, 1'b0, 32'h80FF_FF7F, 0);
      // SH with three cycles of no ack
      do_access(1'b1, 3'b001, 32'h2002, 32'h1234_ABCD, 3, 1'b0, 32'h0, 0);
      // LW misaligned
      do_access(1'b0, 3'b010, 32'h3001, 32'h0, 0, 1'b0, 32'h0, 0);
      // timeout, then ack and err together
      do_access(1'b0, 3'b010, 32'h3004, 32'h0, 99, 1'b0, 32'hDEAD_BEEF, 0);
      do_access(1'b0, 3'b101, 32'h3006, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 0);
      // ack on the last BUSY cycle still counts as success
      do_access(1'b0, 3'b100, 32'h3005, 32'h0, TMO - 1, 1'b0, 32'h1122_8344, 0);
      // hold in DONE for 3 cycles
      do_access(1'b0, 3'b001, 32'h3002, 32'h0, 0, 1'b0, 32'h9876_5432, 3);

      // bus responses outside BUSY are ignored
      bus_ack = 1'b1; bus_err = 1'b1; #1;
      check("idle_ack_buserr", BusErrM, 0);
      @(posedge clk); #1;
      check("idle_ack_req", bus_req, 0);
      check("idle_ack_rdata", ReadDataM, 0);
      bus_ack = 1'b0; bus_err = 1'b0;

      // reset in the middle of BUSY
      MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h4000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midbusy_req", bus_req, 1);
      rst = 1'b1; #1;
      check("midbusy_rst_stall", StallM, 0);
      @(posedge clk); #1;
      check("midbusy_rst_req", bus_req, 0);
      check("midbusy_rst_addr", bus_addr, 0);
      rst = 1'b0; MemReadM = 1'b0; #1;
      check("midbusy_idle_stall", StallM, 0);
      $display("reset during BUSY");
      do_access(1'b0, 3'b010, 32'h5000, 32'h0, 99, 1'b0, 32'h0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), $urandom,
                   int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
